sync_input_conditioner: RTL and testbench
=========================================

Name: sync_input_conditioner

Overview:
Front-end conditioning block for the video format detector.
- Derives a divided clock-enable waveform from the 50 MHz system clock (Clock_divider function).
- Cleans the raw vsync and hsync inputs: synchronises them and removes glitches (simplefilter function, two instances).
- Its outputs feed the format counting logic directly.

Parameters:
- DIVISOR, 28'd2, clock division ratio; clk_div_out period = DIVISOR clocks; legal range 2..2^28-1.
- FILTER_LEN, 8, consecutive clocks a synchronised input must hold a new level before the filtered output follows; legal range 1..255.
- IDLE_LEVEL, 1'b1, reset value of synchroniser stages and filtered outputs (sync inactive level).

Ports:
- clk_50mhz_in  input  1  system clock, 50 MHz
- rst_n_in  input  1  asynchronous active-low reset
- vsync_in  input  1  raw vertical sync, asynchronous to clock
- hsync_in  input  1  raw horizontal sync, asynchronous to clock
- clk_div_out  output  1  divided clock waveform (25 MHz at default)
- vsync_out  output  1  synchronised, deglitched vsync
- hsync_out  output  1  synchronised, deglitched hsync

Behaviour:
- Single clock domain, clk_50mhz_in, all registers on the rising edge.
- rst_n_in low asynchronously clears every register. On release, logic resumes at the next rising edge.
- Reset values:
  - divider counter = 0, clk_div_out = 0
  - both synchroniser stages = IDLE_LEVEL
  - filter counters = 0
  - vsync_out = hsync_out = IDLE_LEVEL
- Divider:
  - 28-bit counter: wraps to 0 when it equals DIVISOR-1, else increments.
  - clk_div_out is registered: clk_div_out <= (counter < DIVISOR/2), evaluated on the pre-update counter value; DIVISOR/2 uses integer division.
  - DIVISOR=2 gives 1,0,1,0… starting at the first edge after reset.
  - Odd DIVISOR: high for floor(DIVISOR/2) clocks, low for the remainder.
  - Output is glitch-free because it comes straight from a flop.
- Filter, identical per channel:
  - Two-flop synchroniser s1 -> s2.
  - Each edge with s2 == out: counter <= 0.
  - Each edge with s2 != out:
    - if counter == FILTER_LEN-1: out <= s2, counter <= 0;
    - else counter increments.
- Filter latency: a clean input level change occurring between two edges appears on the output at the (FILTER_LEN+2)th following rising edge.
- Glitch rejection:
  - Any excursion that lasts fewer than FILTER_LEN synchronised clocks never reaches the output.
  - A bounce back to the output level restarts the count from 0.
- Counter width is ceil(log2(FILTER_LEN+1)); it never exceeds FILTER_LEN-1.
- Channels are fully independent: simultaneous edges on vsync and hsync are each filtered with identical latency.
- Reset asserted mid-filtering discards the partial count; the output returns to IDLE_LEVEL immediately.

Decomposition:
- No shared package needed. Default constants (DIVISOR, FILTER_LEN, IDLE_LEVEL) stay as module parameters.
- One sub-module is natural: sync_glitch_filter, containing the synchroniser, stability counter and output flop, with parameters FILTER_LEN and IDLE_LEVEL. It is instantiated twice, for vsync and hsync.
- The divider stays inline in the top module.

Test Plan:
- Reset then idle, DIVISOR=2: assert rst_n_in low for 5 clocks, release → clk_div_out toggles 1,0,1,0 from the first edge (25 MHz); vsync_out and hsync_out stay 1.
- DIVISOR=5: run 20 clocks → clk_div_out pattern 1,1,0,0,0 repeating, period 5 clocks.
- Clean edge, FILTER_LEN=8: drive vsync_in 1→0 midway between edges and hold → vsync_out falls at exactly the 10th rising edge; 1→0 then back to 1 behaves symmetrically.
- Glitch rejection: hsync_in low pulse of 7 clocks → hsync_out stays 1. Pulse of 8 clocks → hsync_out low for 8 clocks, starting 10 edges after the falling edge.
- Bounce: vsync_in low 5 clocks, high 1 clock, low 8 clocks → single vsync_out fall, 10 edges after the start of the final 8-clock low.
- Mid-operation reset: vsync_in held low for 5 clocks, then rst_n_in pulsed low asynchronously → outputs immediately 1 and clk_div_out 0; after release with vsync_in still low, vsync_out falls 10 edges after release.

Source files
------------

// File: rtl/sync_glitch_filter.sv
// Single-channel input conditioner: two-flop synchroniser followed by a
// stability counter. The output only follows the synchronised input once
// the new level has been seen on FILTER_LEN consecutive clocks.
module sync_glitch_filter #(
    parameter int   FILTER_LEN = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    // Wide enough to hold FILTER_LEN; in practice it never exceeds FILTER_LEN-1.
    localparam int CNT_W = (FILTER_LEN + 1 > 2) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchroniser, count stable clocks of a new level.
    always_comb begin
        s1_d  = din;
        s2_d  = s1_q;
        out_d = out_q;
        cnt_d = '0;
        if (s2_q != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State registers; reset parks everything at the inactive sync level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= IDLE_LEVEL;
            s2_q  <= IDLE_LEVEL;
            out_q <= IDLE_LEVEL;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout = out_q;

endmodule

// File: rtl/sync_input_conditioner.sv
// Front end of the video format detector: produces a divided clock waveform
// from the system clock and cleans the raw vsync/hsync inputs.
module sync_input_conditioner #(
    parameter logic [27:0] DIVISOR    = 28'd2,
    parameter int          FILTER_LEN = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic clk_50mhz_in,
    input  logic rst_n_in,
    input  logic vsync_in,
    input  logic hsync_in,
    output logic clk_div_out,
    output logic vsync_out,
    output logic hsync_out
);

    localparam logic [27:0] DIV_LAST = DIVISOR - 28'd1;
    localparam logic [27:0] DIV_HALF = DIVISOR >> 1;

    logic [27:0] div_cnt_q, div_cnt_d;
    logic        clk_div_q, clk_div_d;

    // Divider next-state: the waveform is judged on the pre-update count so
    // the first edge after reset already drives it high.
    always_comb begin
        clk_div_d = (div_cnt_q < DIV_HALF);
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 28'd1;
        end
    end

    // Divider registers; the output comes straight from a flop, so no glitches.
    always_ff @(posedge clk_50mhz_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt_q <= '0;
            clk_div_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clk_div_q <= clk_div_d;
        end
    end

    assign clk_div_out = clk_div_q;

    // Channel 1 is vsync, channel 0 is hsync; both use identical filters.
    logic [1:0] raw_in;
    logic [1:0] clean_out;

    assign raw_in = {vsync_in, hsync_in};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            sync_glitch_filter #(
                .FILTER_LEN (FILTER_LEN),
                .IDLE_LEVEL (IDLE_LEVEL)
            ) u_filter (
                .clk   (clk_50mhz_in),
                .rst_n (rst_n_in),
                .din   (raw_in[gi]),
                .dout  (clean_out[gi])
            );
        end
    endgenerate

    assign vsync_out = clean_out[1];
    assign hsync_out = clean_out[0];

endmodule

// File: tb/tb_sync_input_conditioner.sv
// Directed bench for sync_input_conditioner: divider patterns for DIVISOR 2
// and 5, filter latency, glitch rejection, bounce and mid-run reset.
module tb_sync_input_conditioner;

    logic clk = 1'b0;
    logic rst_n;
    logic vsync_in;
    logic hsync_in;
    logic clk_div2, vsync_o, hsync_o;
    logic clk_div5, vsync_o5, hsync_o5;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    sync_input_conditioner dut (
        .clk_50mhz_in (clk),
        .rst_n_in     (rst_n),
        .vsync_in     (vsync_in),
        .hsync_in     (hsync_in),
        .clk_div_out  (clk_div2),
        .vsync_out    (vsync_o),
        .hsync_out    (hsync_o)
    );

    sync_input_conditioner #(.DIVISOR(28'd5)) dut5 (
        .clk_50mhz_in (clk),
        .rst_n_in     (rst_n),
        .vsync_in     (vsync_in),
        .hsync_in     (hsync_in),
        .clk_div_out  (clk_div5),
        .vsync_out    (vsync_o5),
        .hsync_out    (hsync_o5)
    );

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, midway between rising edges.
    task automatic to_mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        vsync_in = 1'b1;
        hsync_in = 1'b1;

        // Reset held for 5 clocks.
        repeat (5) tick();
        chk("rst_clkdiv2", clk_div2, 1'b0);
        chk("rst_clkdiv5", clk_div5, 1'b0);
        chk("rst_vsync",   vsync_o,  1'b1);
        chk("rst_hsync",   hsync_o,  1'b1);
        $display("step reset: clk_div2=%b clk_div5=%b vsync=%b hsync=%b", clk_div2, clk_div5, vsync_o, hsync_o);

        // Release and observe divider patterns with idle inputs.
        to_mid();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("div2_pattern", clk_div2, (i % 2) == 0);
            chk("div5_pattern", clk_div5, (i % 5) < 2);
            chk("idle_vsync", vsync_o, 1'b1);
            chk("idle_hsync", hsync_o, 1'b1);
            $display("step div edge %0d: div2=%b div5=%b", i + 1, clk_div2, clk_div5);
        end

        // Clean falling edge on vsync: output falls on the 10th edge.
        to_mid();
        vsync_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("clean_fall_vsync", vsync_o, (k < 10) ? 1'b1 : 1'b0);
            chk("clean_fall_hsync", hsync_o, 1'b1);
            $display("step clean fall edge %0d: vsync_out=%b", k, vsync_o);
        end

        // Clean rising edge back: symmetric latency.
        to_mid();
        vsync_in = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("clean_rise_vsync", vsync_o, (k < 10) ? 1'b0 : 1'b1);
            $display("step clean rise edge %0d: vsync_out=%b", k, vsync_o);
        end

        // 7-clock hsync low pulse: rejected.
        to_mid();
        hsync_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("glitch7_hsync", hsync_o, 1'b1);
            $display("step glitch7 edge %0d: hsync_out=%b", k, hsync_o);
            if (k == 7) begin
                to_mid();
                hsync_in = 1'b1;
            end
        end

        // 8-clock hsync low pulse: passes, low on edges 10..17.
        to_mid();
        hsync_in = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk("pulse8_hsync", hsync_o, (k >= 10 && k <= 17) ? 1'b0 : 1'b1);
            chk("pulse8_vsync", vsync_o, 1'b1);
            $display("step pulse8 edge %0d: hsync_out=%b", k, hsync_o);
            if (k == 8) begin
                to_mid();
                hsync_in = 1'b1;
            end
        end

        // Bounce: low 5, high 1, low 8 then high. Final low starts in the
        // interval before edge 7, so vsync_out falls at edge 16 and rises at 24.
        to_mid();
        vsync_in = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            tick();
            chk("bounce_vsync", vsync_o, (k >= 16 && k <= 23) ? 1'b0 : 1'b1);
            $display("step bounce edge %0d: vsync_out=%b", k, vsync_o);
            if (k == 5) begin
                to_mid();
                vsync_in = 1'b1;
            end else if (k == 6) begin
                to_mid();
                vsync_in = 1'b0;
            end else if (k == 14) begin
                to_mid();
                vsync_in = 1'b1;
            end
        end

        // Mid-operation reset with vsync held low.
        to_mid();
        vsync_in = 1'b0;
        repeat (5) tick();
        chk("prerst_vsync", vsync_o, 1'b1);
        #4;
        rst_n = 1'b0;
        #1;
        chk("midrst_vsync",    vsync_o,  1'b1);
        chk("midrst_hsync",    hsync_o,  1'b1);
        chk("midrst_clkdiv2",  clk_div2, 1'b0);
        chk("midrst_clkdiv5",  clk_div5, 1'b0);
        $display("step mid reset: vsync=%b hsync=%b div2=%b div5=%b", vsync_o, hsync_o, clk_div2, clk_div5);
        to_mid();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("postrst_vsync", vsync_o, (k < 10) ? 1'b1 : 1'b0);
            chk("postrst_clkdiv2", clk_div2, (k % 2) == 1);
            $display("step post reset edge %0d: vsync_out=%b div2=%b", k, vsync_o, clk_div2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
